// File: rtl/grid_monitor.sv
// Grid monitor: classifies grid ADC samples as OK/UNSTABLE/OUTAGE with voltage hysteresis,
// asymmetric debounce and a sample timeout. Define GRID_MON_AVG_EN for 4-sample voltage averaging.
package sc_types_pkg;
    typedef enum logic [1:0] {
        GS_OK       = 2'd0,
        GS_UNSTABLE = 2'd1,
        GS_OUTAGE   = 2'd2
    } grid_state_t;
endpackage

module grid_monitor
    import sc_types_pkg::*;
#(
    parameter logic [11:0] V_OUT_MIN   = 12'd800,
    parameter logic [11:0] V_LO        = 12'd2070,
    parameter logic [11:0] V_HI        = 12'd2530,
    parameter logic [12:0] F_LO        = 13'd4950,
    parameter logic [12:0] F_HI        = 13'd5050,
    parameter logic [11:0] V_HYST      = 12'd20,
    parameter int          DEB_UP      = 3,
    parameter int          DEB_DOWN    = 8,
    parameter int          TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    // sample_valid is a one-cycle strobe with no back-pressure: every strobe is consumed.
    input  logic        sample_valid,
    input  logic [11:0] v_sample,
    input  logic [12:0] f_sample,
    output grid_state_t grid_state,
    output logic        grid_state_valid,
    output logic        state_change,
    output logic        sample_stale,
    output logic [7:0]  instab_count
);

    localparam int              TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TO_MAX     = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      DEB_UP_C   = 4'(DEB_UP);
    localparam logic [3:0]      DEB_DOWN_C = 4'(DEB_DOWN);

    logic          timeout_fire;
    logic [TW-1:0] to_cnt;

    logic          cls_valid;
    logic [11:0]   cls_v;
    logic [12:0]   cls_f;

    grid_state_t   raw;
    grid_state_t   cand;
    grid_state_t   nxt_cand;
    logic [3:0]    deb_cnt;
    logic [3:0]    nxt_cnt;
    logic [3:0]    req_cnt;
    logic [11:0]   vl;
    logic [11:0]   vh;
    logic          do_update;

    // The firing cycle is the one that would take the idle count to TIMEOUT_CYC;
    // a strobe on that cycle takes precedence.
    assign timeout_fire = !sample_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (sample_valid) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef GRID_MON_AVG_EN
    logic [11:0] v_h0;
    logic [11:0] v_h1;
    logic [11:0] v_h2;
    logic [13:0] v_sum;

    always_comb begin
        v_sum = 14'(v_sample) + 14'(v_h0) + 14'(v_h1) + 14'(v_h2);
    end

    // Averaged voltage is registered, so classification runs one cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_h0      <= '0;
            v_h1      <= '0;
            v_h2      <= '0;
            cls_valid <= 1'b0;
            cls_v     <= '0;
            cls_f     <= '0;
        end else begin
            cls_valid <= sample_valid;
            if (sample_valid) begin
                v_h0  <= v_sample;
                v_h1  <= v_h0;
                v_h2  <= v_h1;
                cls_v <= 12'(v_sum >> 2);
                cls_f <= f_sample;
            end else if (timeout_fire) begin
                v_h0 <= '0;
                v_h1 <= '0;
                v_h2 <= '0;
            end
        end
    end
`else
    always_comb begin
        cls_valid = sample_valid;
        cls_v     = v_sample;
        cls_f     = f_sample;
    end
`endif

    always_comb begin
        if (grid_state == GS_UNSTABLE) begin
            vl = V_LO + V_HYST;
            vh = V_HI - V_HYST;
        end else begin
            vl = V_LO;
            vh = V_HI;
        end

        if (cls_v < V_OUT_MIN) begin
            raw = GS_OUTAGE;
        end else if (cls_v < vl || cls_v > vh || cls_f < F_LO || cls_f > F_HI) begin
            raw = GS_UNSTABLE;
        end else begin
            raw = GS_OK;
        end

        // Encoding order equals severity order, so a numeric compare suffices.
        req_cnt = (raw > grid_state) ? DEB_UP_C : DEB_DOWN_C;

        nxt_cand = cand;
        nxt_cnt  = deb_cnt;
        if (raw == grid_state) begin
            nxt_cnt = 4'd0;
        end else if (raw == cand) begin
            nxt_cnt = deb_cnt + 4'd1;
        end else begin
            nxt_cand = raw;
            nxt_cnt  = 4'd1;
        end

        do_update = cls_valid && (raw != grid_state) && (nxt_cnt >= req_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_state       <= GS_OUTAGE;
            grid_state_valid <= 1'b0;
            state_change     <= 1'b0;
            sample_stale     <= 1'b0;
            instab_count     <= 8'd0;
            cand             <= GS_OUTAGE;
            deb_cnt          <= 4'd0;
        end else begin
            state_change <= 1'b0;
            if (sample_valid) begin
                sample_stale <= 1'b0;
            end

            if (timeout_fire) begin
                grid_state       <= GS_OUTAGE;
                state_change     <= (grid_state != GS_OUTAGE);
                sample_stale     <= 1'b1;
                grid_state_valid <= 1'b1;
                cand             <= GS_OUTAGE;
                deb_cnt          <= 4'd0;
            end else if (cls_valid) begin
                cand <= nxt_cand;
                if (do_update) begin
                    grid_state       <= raw;
                    state_change     <= 1'b1;
                    grid_state_valid <= 1'b1;
                    deb_cnt          <= 4'd0;
                    if (grid_state == GS_OK && raw == GS_UNSTABLE && instab_count != 8'hFF) begin
                        instab_count <= instab_count + 8'd1;
                    end
                end else begin
                    deb_cnt <= nxt_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_monitor.sv
// Directed bench for grid_monitor: a sample-history model of the debounce rules checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_grid_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] v_sample = 12'd0;
    logic [12:0] f_sample = 13'd0;
    logic [1:0]  grid_state;
    logic        grid_state_valid;
    logic        state_change;
    logic        sample_stale;
    logic [7:0]  instab_count;

    int total = 0;
    int bad = 0;

    grid_monitor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_valid     (sample_valid),
        .v_sample         (v_sample),
        .f_sample         (f_sample),
        .grid_state       (grid_state),
        .grid_state_valid (grid_state_valid),
        .state_change     (state_change),
        .sample_stale     (sample_stale),
        .instab_count     (instab_count)
    );

    always #5 clk = ~clk;

    // Model state: 0=OK, 1=UNSTABLE, 2=OUTAGE
    int m_state = 2;
    int m_valid = 0;
    int m_stale = 0;
    int m_instab = 0;
    int m_change = 0;
    int m_idle = 0;
    int m_hist[$];
    logic [1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input int v, input int f, input int st);
        int vl;
        int vh;
        vl = (st == 1) ? 2090 : 2070;
        vh = (st == 1) ? 2510 : 2530;
        if (v < 800) return 2;
        if (v < vl || v > vh || f < 4950 || f > 5050) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 2;
        m_valid = 0;
        m_stale = 0;
        m_instab = 0;
        m_change = 0;
        m_idle = 0;
        m_hist.delete();
        exp_q.delete();
    endtask

    // A state moves once the most recent `need` samples since the last update all agree.
    task automatic model_step();
        int raw;
        int need;
        bit agree;
        m_change = 0;
        if (sample_valid) begin
            m_idle = 0;
            m_stale = 0;
            raw = classify(int'(v_sample), int'(f_sample), m_state);
            m_hist.push_back(raw);
            need = (raw > m_state) ? 3 : 8;
            agree = (raw != m_state) && (m_hist.size() >= need);
            for (int i = 0; i < need && agree; i++)
                if (m_hist[m_hist.size() - 1 - i] != raw) agree = 0;
            if (agree) begin
                if (m_state == 0 && raw == 1 && m_instab < 255) m_instab++;
                m_state = raw;
                m_change = 1;
                m_valid = 1;
                m_hist.delete();
                exp_q.push_back(2'(raw));
            end
        end else if (m_idle < 1000) begin
            m_idle++;
            if (m_idle == 1000) begin
                if (m_state != 2) begin
                    m_change = 1;
                    exp_q.push_back(2'd2);
                end
                m_state = 2;
                m_stale = 1;
                m_valid = 1;
                m_hist.delete();
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        logic [1:0] exp_new;
        forever begin
            @(negedge clk);
            check("grid_state", int'(grid_state), m_state);
            check("grid_state_valid", int'(grid_state_valid), m_valid);
            check("state_change", int'(state_change), m_change);
            check("sample_stale", int'(sample_stale), m_stale);
            check("instab_count", int'(instab_count), m_instab);
            if (state_change) begin
                exp_new = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd3;
                check("change_target", int'(grid_state), int'(exp_new));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive_now(input int v, input int f);
        sample_valid = 1'b1;
        v_sample = 12'(v);
        f_sample = 13'(f);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send(input int v, input int f, input int n);
        repeat (n) begin
            @(negedge clk);
            drive_now(v, f);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(grid_state), 2);
        check("rst_valid", int'(grid_state_valid), 0);
        check("rst_change", int'(state_change), 0);
        check("rst_stale", int'(sample_stale), 0);
        check("rst_instab", int'(instab_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // OUTAGE -> OK needs eight good samples
        send(2300, 5000, 7);
        check("ok_not_yet", int'(grid_state), 2);
        send(2300, 5000, 1);
        check("ok_after_8", int'(grid_state), 0);
        check("ok_change", int'(state_change), 1);
        check("ok_valid", int'(grid_state_valid), 1);
        @(negedge clk);
        check("change_one_cycle", int'(state_change), 0);

        // interrupted run, then three high-voltage samples
        send(2600, 5000, 2);
        send(2300, 5000, 1);
        send(2600, 5000, 2);
        check("unst_not_yet", int'(grid_state), 0);
        send(2600, 5000, 1);
        check("unst_after_3", int'(grid_state), 1);
        check("instab_1", int'(instab_count), 1);

        // hysteresis narrows the window to [2090, 2510]
        send(2520, 5000, 8);
        check("hyst_hold", int'(grid_state), 1);
        send(2500, 5000, 8);
        check("hyst_release", int'(grid_state), 0);

        // frequency excursions on both sides, then deep undervoltage
        send(2300, 4940, 1);
        send(2300, 5060, 1);
        send(2300, 4900, 1);
        check("freq_unst", int'(grid_state), 1);
        check("instab_2", int'(instab_count), 2);
        send(500, 5000, 3);
        check("outage", int'(grid_state), 2);
        check("instab_outage", int'(instab_count), 2);
        send(2300, 5000, 8);
        check("recover_ok", int'(grid_state), 0);

        // strobe on the would-be firing cycle wins
        repeat (999) @(negedge clk);
        check("pre_to_state", int'(grid_state), 0);
        drive_now(2300, 5000);
        check("to_avoided_state", int'(grid_state), 0);
        check("to_avoided_stale", int'(sample_stale), 0);

        // full timeout
        repeat (999) @(negedge clk);
        check("to_edge_state", int'(grid_state), 0);
        check("to_edge_stale", int'(sample_stale), 0);
        @(negedge clk);
        check("to_state", int'(grid_state), 2);
        check("to_stale", int'(sample_stale), 1);
        check("to_change", int'(state_change), 1);
        check("to_valid", int'(grid_state_valid), 1);
        repeat (5) @(negedge clk);
        check("stale_hold", int'(sample_stale), 1);
        check("stale_no_pulse", int'(state_change), 0);
        send(2300, 5000, 1);
        check("stale_clear", int'(sample_stale), 0);
        check("stale_clear_state", int'(grid_state), 2);
        send(2300, 5000, 7);
        check("after_to_ok", int'(grid_state), 0);

        // saturate the instability counter
        for (int k = 0; k < 260; k++) begin
            send(2600, 5000, 3);
            send(2500, 5000, 8);
        end
        check("instab_sat", int'(instab_count), 255);
        check("sat_state", int'(grid_state), 0);

        // reset in the middle of a debounce run
        send(2600, 5000, 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", int'(grid_state), 2);
        check("midrst_valid", int'(grid_state_valid), 0);
        check("midrst_change", int'(state_change), 0);
        check("midrst_stale", int'(sample_stale), 0);
        check("midrst_instab", int'(instab_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(2600, 5000, 3);
        check("no_carry_state", int'(grid_state), 2);
        check("no_carry_valid", int'(grid_state_valid), 0);

        repeat (2) @(negedge clk);
        check("pending_changes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_monitor.md
Name: grid_monitor

Overview:
- Upstream stage of the charge-control FSM and the safety block; produces the `grid_state` they both consume.
- Takes periodic voltage/frequency samples from the grid ADC front end and classifies each one as OK, UNSTABLE or OUTAGE.
- Applies hysteresis and asymmetric debouncing before publishing the state.
- Forces OUTAGE when samples stop arriving.

Parameters:
- V_OUT_MIN, 12'd800, voltage below this is raw OUTAGE (0.1 V units, i.e. 80.0 V)
- V_LO, 12'd2070, lower normal voltage bound (207.0 V)
- V_HI, 12'd2530, upper normal voltage bound (253.0 V)
- F_LO, 13'd4950, lower normal frequency bound (49.50 Hz, 0.01 Hz units)
- F_HI, 13'd5050, upper normal frequency bound (50.50 Hz)
- V_HYST, 12'd20, voltage window shrink applied while state is UNSTABLE
- DEB_UP, 3, consecutive samples needed to move to a more severe state
- DEB_DOWN, 8, consecutive samples needed to move to a less severe state
- TIMEOUT_CYC, 1000, cycles without `sample_valid` before forced OUTAGE

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_valid  input  1  one-cycle strobe; `v_sample`/`f_sample` valid this cycle
- v_sample  input  12  grid RMS voltage, 0.1 V/LSB, unsigned
- f_sample  input  13  grid frequency, 0.01 Hz/LSB, unsigned
- grid_state  output  2  sc_types_pkg::grid_state_t: OK=2'd0, UNSTABLE=2'd1, OUTAGE=2'd2
- grid_state_valid  output  1  high after the first debounced decision
- state_change  output  1  one-cycle pulse when `grid_state` changes
- sample_stale  output  1  high while a sample timeout is in effect
- instab_count  output  8  saturating count of OK→UNSTABLE transitions

Behaviour:
- Reset (asynchronous, `rst_n`=0): `grid_state`=OUTAGE, `grid_state_valid`=0, `state_change`=0, `sample_stale`=0, `instab_count`=0. Internal candidate=OUTAGE, debounce count=0, timeout counter=0.
- Raw classification is applied per valid sample, with priority:
  - `v` < V_OUT_MIN → OUTAGE.
  - Else `v` outside [VL, VH] or `f` outside [F_LO, F_HI] → UNSTABLE.
  - Else → OK.
  - Comparisons are inclusive at the bounds.
  - When `grid_state`==UNSTABLE: VL = V_LO+V_HYST and VH = V_HI−V_HYST. Otherwise VL = V_LO and VH = V_HI. No hysteresis on frequency.
- Severity ordering: OK < UNSTABLE < OUTAGE. The required count is DEB_UP if the candidate is more severe than `grid_state`, else DEB_DOWN.
- Debounce, evaluated on each valid sample:
  - raw == `grid_state` → count=0.
  - raw == candidate → count+1.
  - Otherwise → candidate=raw, count=1.
  - When the updated count reaches the required count, `grid_state` takes raw at that same edge and count resets to 0.
  - Net effect: `grid_state` updates one cycle after the strobe of the completing sample.
- `state_change`: pulses for exactly the one cycle in which the new `grid_state` is first visible.
- `grid_state_valid`: set on the first debounced update or on a timeout; stays set until reset.
- `instab_count`: increments on each OK→UNSTABLE update; saturates at 255. OK→OUTAGE and UNSTABLE→OUTAGE do not count.
- Timeout:
  - The timeout counter increments each cycle without `sample_valid` and clears on `sample_valid`.
  - When it reaches TIMEOUT_CYC: `grid_state`=OUTAGE (with a `state_change` pulse if it was not already OUTAGE), `sample_stale`=1, candidate/count cleared. The counter then holds at TIMEOUT_CYC.
  - `sample_stale` clears on the next `sample_valid`, which is classified normally.
  - If `sample_valid` arrives on the same cycle the timeout would fire, the sample wins and no timeout occurs.
- Encoding 2'd3 is never output.
- Deasserting `rst_n` mid-debounce discards all progress.

Optional Feature:
- Macro: GRID_MON_AVG_EN.
- Defined:
  - Voltage is replaced by the 4-sample moving average (sum of the last four valid `v_sample` values, 14-bit, >>2) before classification. Frequency is not averaged.
  - The averaged classification is registered one cycle after the strobe, so `grid_state` latency becomes two cycles after the completing sample.
  - The history is zero-filled at reset and on timeout.
  - `state_change` and `instab_count` behave identically, aligned to the new update edge.
- Undefined: raw `v_sample` is classified directly, with the single-cycle latency above.

Test Plan:
- Reset, then 8 samples of v=2300, f=5000 → `grid_state` OUTAGE→OK after the 8th (DEB_DOWN); `state_change` pulses once; `grid_state_valid`=1.
- From OK: 2 samples v=2600 then 1 sample v=2300 → no change, count cleared. Then 3 samples v=2600 → UNSTABLE; `instab_count`=1.
- UNSTABLE hysteresis: 8 samples v=2520 (<V_HI but >2510) → stays UNSTABLE. Then 8 samples v=2500 → OK.
- From OK: samples f=4940, f=5060, f=4900 (all UNSTABLE candidates) → UNSTABLE after the 3rd. Then v=500 ×3 → OUTAGE; `instab_count` unchanged by the OUTAGE transition.
- From OK: no `sample_valid` for 1000 cycles → OUTAGE, `sample_stale`=1, `state_change` pulse. A `sample_valid` at cycle 999 instead → no timeout.
- OK→UNSTABLE repeated 260 times → `instab_count` saturates at 255. Assert `rst_n` low mid-debounce → all outputs at reset values immediately.
